// File: rtl/seg_display_scanner_pkg.sv
// Shared constants for the debug seven-segment display scanner:
// hex-to-segment table (active-low g..a), blank pattern and dp bit position.
package seg_disp_pkg;

    // Segment pattern with every segment off, including the decimal point.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Position of the decimal point within the 8-bit segment bus.
    localparam int DP_BIT = 7;

    // Active-low g..a patterns for hex digits 0..F (dp not included).
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_display_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module hex_to_seg
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Look up the segment pattern for the nibble.
    always_comb begin
        seg_n = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Multi-channel debug display scanner: selects one probe word (manual or
// auto-rotating), snapshots it once per scan frame and time-multiplexes its
// hex digits onto one active-low 8-segment bus.
// Optional build macro LEAD_ZERO_BLANK_EN: blank digits above the most
// significant nonzero nibble (digit 0 always shown).
module seg_display_scanner
    import seg_disp_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 32,
    parameter int SCAN_DIV     = 50000,
    parameter int DWELL_FRAMES = 256,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [CH_W-1:0]          choose,
    input  logic                     auto_en,
    output logic [2:0]               which,
    output logic [7:0]               seg,
    output logic [CH_W-1:0]          ch_idx,
    output logic                     frame_start
);

    localparam int DIGITS = DATA_W / 4;
    localparam int PW     = $clog2(SCAN_DIV);
    localparam int FW     = $clog2(DWELL_FRAMES + 1);

    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]      DIGIT_LAST = 3'(DIGITS - 1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(DWELL_FRAMES - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   NUM_CH_V   = (CH_W + 1)'(NUM_CH);

    logic [PW-1:0]     presc_q, presc_d;
    logic [2:0]        digit_q, digit_d;
    logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic              auto_last_q, auto_last_d;
    logic [2:0]        which_q, which_d;
    logic [7:0]        seg_q, seg_d;
    logic              frame_start_q, frame_start_d;

    logic              tick_s;
    logic              frame_end_s;
    logic              choose_ok_s;
    logic [3:0]        nibble_s;
    logic [6:0]        hex_pat_s;
    logic [7:0]        seg_pat_s;

`ifdef LEAD_ZERO_BLANK_EN
    // Index of the most significant nonzero nibble; 0 when the word is zero.
    function automatic logic [2:0] top_nonzero(input logic [DATA_W-1:0] w);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] != 4'h0) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction
`endif

    // Prescaler, digit counter and frame-end detection.
    always_comb begin
        tick_s      = (presc_q == PRESC_LAST);
        frame_end_s = tick_s && (digit_q == DIGIT_LAST);
        if (tick_s) begin
            presc_d = '0;
            if (digit_q == DIGIT_LAST) begin
                digit_d = 3'd0;
            end else begin
                digit_d = digit_q + 3'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
            digit_d = digit_q;
        end
    end

    // Channel selection, dwell counting and snapshot, all applied at frame end.
    always_comb begin
        choose_ok_s = ({1'b0, choose} < NUM_CH_V);
        frame_cnt_d = frame_cnt_q;
        ch_idx_d    = ch_idx_q;
        snap_d      = snap_q;
        auto_last_d = auto_last_q;
        if (frame_end_s) begin
            auto_last_d = auto_en;
            if (auto_en != auto_last_q) begin
                // Mode changed since the previous frame: restart the dwell.
                frame_cnt_d = '0;
            end else if (auto_en) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_d = '0;
                    if (ch_idx_q == CH_LAST) begin
                        ch_idx_d = '0;
                    end else begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                end
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
            if (!auto_en && choose_ok_s) begin
                ch_idx_d = choose;
            end else begin
                ch_idx_d = ch_idx_d;
            end
            snap_d = ch_data[int'(ch_idx_d)*DATA_W +: DATA_W];
        end else begin
            snap_d = snap_q;
        end
    end

    // Select the nibble for the digit about to be shown (new snapshot at frame end).
    always_comb begin
        nibble_s = snap_d[4*int'(digit_d) +: 4];
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble_s),
        .seg_n  (hex_pat_s)
    );

    // Compose the full segment pattern: optional blanking, then dp indicator.
    always_comb begin
        seg_pat_s = {1'b1, hex_pat_s};
`ifdef LEAD_ZERO_BLANK_EN
        if ((digit_d != 3'd0) && (digit_d > top_nonzero(snap_d))) begin
            seg_pat_s = SEG_BLANK;
        end else begin
            seg_pat_s = seg_pat_s;
        end
`endif
        if ((digit_d == 3'd0) && auto_en) begin
            seg_pat_s[DP_BIT] = 1'b0;
        end else begin
            seg_pat_s = seg_pat_s;
        end
    end

    // Registered display outputs change only on a digit tick.
    always_comb begin
        frame_start_d = frame_end_s;
        if (tick_s) begin
            which_d = digit_d;
            seg_d   = seg_pat_s;
        end else begin
            which_d = which_q;
            seg_d   = seg_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            digit_q       <= 3'd0;
            frame_cnt_q   <= '0;
            ch_idx_q      <= '0;
            snap_q        <= '0;
            auto_last_q   <= 1'b0;
            which_q       <= 3'd0;
            seg_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            digit_q       <= digit_d;
            frame_cnt_q   <= frame_cnt_d;
            ch_idx_q      <= ch_idx_d;
            snap_q        <= snap_d;
            auto_last_q   <= auto_last_d;
            which_q       <= which_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign which       = which_q;
    assign seg         = seg_q;
    assign ch_idx      = ch_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (SCAN_DIV=4, DATA_W=16,
// NUM_CH=3, DWELL_FRAMES=2). Honors LEAD_ZERO_BLANK_EN when defined.
module tb_seg_display_scanner;

    localparam int NUM_CH   = 3;
    localparam int DATA_W   = 16;
    localparam int SCAN_DIV = 4;
    localparam int DWELL    = 2;
    localparam int DIGITS   = 4;
    localparam int CH_W     = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [CH_W-1:0]          choose;
    logic                     auto_en;
    logic [2:0]               which;
    logic [7:0]               seg;
    logic [CH_W-1:0]          ch_idx;
    logic                     frame_start;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .NUM_CH       (NUM_CH),
        .DATA_W       (DATA_W),
        .SCAN_DIV     (SCAN_DIV),
        .DWELL_FRAMES (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_data     (ch_data),
        .choose      (choose),
        .auto_en     (auto_en),
        .which       (which),
        .seg         (seg),
        .ch_idx      (ch_idx),
        .frame_start (frame_start)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0] seg_tbl [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct {
        logic [15:0] word;
        logic [31:0] segs;   // digit d expected in bits [8*d +: 8]
    } vec_t;
    vec_t vecs [4];

    int auto_seq [7] = '{0, 0, 1, 1, 2, 2, 0};

    // Reference model state: time since reset in clock edges, frame-level channel state.
    int          k;
    int          m_ch, m_fc, m_last_auto;
    logic [15:0] m_snap;
    int          e_which, e_seg, e_fs;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_pattern(logic [15:0] w, int d, bit au);
        int p;
        p = int'(seg_tbl[(w >> (4*d)) & 16'hF]);
`ifdef LEAD_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < DIGITS; i++)
                if (((w >> (4*i)) & 16'hF) != 0) top = i;
            if (d > top) p = 'hFF;
        end
`endif
        if (d == 0 && au) p = p & 'h7F;
        return p;
    endfunction

    // One clock edge: advance the model using the inputs present at the edge, then check.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            k = 0; m_ch = 0; m_fc = 0; m_last_auto = 0; m_snap = 16'h0;
            e_which = 0; e_seg = 'hFF; e_fs = 0;
        end else begin
            k++;
            e_fs = 0;
            if (k % SCAN_DIV == 0) begin
                int nd;
                nd = (k / SCAN_DIV) % DIGITS;
                if (nd == 0) begin
                    if (int'(auto_en) != m_last_auto) m_fc = 0;
                    else if (auto_en) begin
                        if (m_fc == DWELL - 1) begin
                            m_fc = 0;
                            m_ch = (m_ch + 1) % NUM_CH;
                        end else m_fc++;
                    end
                    if (!auto_en && int'(choose) < NUM_CH) m_ch = int'(choose);
                    m_last_auto = int'(auto_en);
                    m_snap = ch_data[m_ch*DATA_W +: DATA_W];
                    e_fs = 1;
                end
                e_which = nd;
                e_seg   = exp_pattern(m_snap, nd, auto_en);
            end
        end
        #1;
        chk("model_which", int'(which), e_which);
        chk("model_seg", int'(seg), e_seg);
        chk("model_ch_idx", int'(ch_idx), m_ch);
        chk("model_frame_start", int'(frame_start), e_fs);
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 200; i++) begin
            step();
            if (frame_start) return;
        end
        chk("frame_start_timeout", 0, 1);
    endtask

    initial begin
        vecs[0] = '{16'h1A2F, 32'hF9_88_A4_8E};
        vecs[1] = '{16'h89AB, 32'h80_90_88_83};
        vecs[2] = '{16'hCDE7, 32'hC6_A1_86_F8};
        vecs[3] = '{16'h4565, 32'h99_92_82_92};

        rst = 1'b1; auto_en = 1'b0; choose = '0; ch_data = '0;

        // Scenario 1: reset then first tick and first frame_start timing.
        steps(3);
        chk("rst_which", int'(which), 0);
        chk("rst_seg", int'(seg), 'hFF);
        chk("rst_frame_start", int'(frame_start), 0);
        rst = 1'b0;
        begin
            int first_fs;
            first_fs = -1;
            for (int i = 1; i <= 16; i++) begin
                step();
                if (i == 3) chk("pre_tick_seg", int'(seg), 'hFF);
                if (i == 4) begin
                    chk("tick1_which", int'(which), 1);
`ifdef LEAD_ZERO_BLANK_EN
                    chk("tick1_seg", int'(seg), 'hFF);
`else
                    chk("tick1_seg", int'(seg), 'hC0);
`endif
                end
                if (frame_start && first_fs < 0) first_fs = i;
            end
            chk("first_frame_start_cycle", first_fs, 16);
        end

        // Scenario 2 + table: manual channel 1, digit patterns over a frame.
        choose = 2'd1;
        for (int v = 0; v < 4; v++) begin
            ch_data[DATA_W +: DATA_W] = vecs[v].word;
            wait_fs();
            for (int d = 0; d < DIGITS; d++) begin
                if (d > 0) steps(SCAN_DIV);
                chk("table_which", int'(which), d);
                chk("table_seg", int'(seg), int'(vecs[v].segs[8*d +: 8]));
                chk("table_ch_idx", int'(ch_idx), 1);
            end
        end

        // Scenario 3: mid-frame data change is not displayed until next frame.
        ch_data[DATA_W +: DATA_W] = 16'h1A2F;
        wait_fs();
        steps(2*SCAN_DIV);
        ch_data[DATA_W +: DATA_W] = 16'hFFFF;
        steps(SCAN_DIV);
        chk("midframe_hold_seg", int'(seg), 'hF9);
        wait_fs();
        for (int d = 0; d < DIGITS; d++) begin
            if (d > 0) steps(SCAN_DIV);
            chk("after_update_seg", int'(seg), 'h8E);
        end

        // Scenario 4: out-of-range choose holds the channel.
        choose = 2'd3;
        for (int f = 0; f < 3; f++) begin
            wait_fs();
            chk("oor_choose_ch_idx", int'(ch_idx), 1);
        end

        // Scenario 5: auto rotation after reset, dp lit on digit 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        auto_en = 1'b1;
        for (int f = 0; f < 7; f++) begin
            wait_fs();
            chk("auto_ch_seq", int'(ch_idx), auto_seq[f]);
            chk("auto_dp_digit0", int'(seg[7]), 0);
        end

`ifdef LEAD_ZERO_BLANK_EN
        // Scenario 6: leading-zero blanking.
        auto_en = 1'b0;
        choose  = 2'd0;
        ch_data[0 +: DATA_W] = 16'h0030;
        wait_fs();
        wait_fs();
        for (int d = 0; d < DIGITS; d++) begin
            if (d > 0) steps(SCAN_DIV);
            chk("lzb_0030_seg", int'(seg), (d == 0) ? 'hC0 : (d == 1) ? 'hB0 : 'hFF);
        end
        ch_data[0 +: DATA_W] = 16'h0000;
        wait_fs();
        for (int d = 0; d < DIGITS; d++) begin
            if (d > 0) steps(SCAN_DIV);
            chk("lzb_zero_seg", int'(seg), (d == 0) ? 'hC0 : 'hFF);
        end
`endif

        // Randomized phase against the reference model.
        for (int i = 0; i < 3000; i++) begin
            ch_data = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 15) == 0) choose = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        steps(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
